stream_fragmenter: RTL and testbench

Splits a byte stream into output beats whose sizes are set per beat by a request channel. It is the consumer-side counterpart of stream_normalizer: it takes a dense stream (all beats full except the last) and re-fragments it into beats of arbitrary size. It sits in front of any block that consumes variable-size chunks, such as header parsers or width-limited sinks.

---
 rtl/stream_fragmenter.sv | 150 +++++++++++++++
 tb/tb_stream_fragmenter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fragmenter.sv
// stream_fragmenter
//   Re-cuts a dense byte stream (every beat full except the packet's last)
//   into output beats whose sizes are chosen one beat at a time by a
//   request channel. Up to two input beats are held in a byte buffer. The
//   output beat is formed combinationally from the held bytes and the
//   current request. A packet's tail is never merged with the next packet:
//   input is refused while the final bytes of a packet are still held.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_cnt      input bytes (byte 0 first) and valid-bytes-minus-1
//   in_last             input beat ends the packet
//   in_valid/in_ready   input handshake (in_ready is registered)
//   req_cnt             requested bytes minus 1 for the next output beat
//   req_valid/req_ready request handshake (req_ready == output transfer)
//   out_data/out_cnt    output bytes packed from byte 0, unused bytes zero
//   out_last            beat carries the final byte of the packet
//   out_valid/out_ready output handshake

// One buffer byte position: next value after the per-edge shift and append.
// Surviving bytes slide down by `taken`; new bytes land just above them.
module stream_fragmenter_slot #(
  parameter int DATA_BYTES = 8,
  parameter int IDX        = 0,
  localparam int CW = $clog2(DATA_BYTES),
  localparam int AW = CW + 1,
  localparam int OW = $clog2(2*DATA_BYTES+1)
) (
  input  logic [2*DATA_BYTES-1:0][7:0] buf_q,
  input  logic [DATA_BYTES-1:0][7:0]   in_arr,
  input  logic [AW-1:0]                taken,
  input  logic [OW-1:0]                keep,
  input  logic [OW-1:0]                added,
  output logic [7:0]                   slot_d
);
  localparam logic [OW-1:0] POS = OW'(IDX);

  logic [AW-1:0] src;
  logic [OW-1:0] wr;

  always_comb begin
    // src only matters when POS < keep, so src < occ <= 2*DATA_BYTES fits AW bits
    src    = AW'(IDX) + taken;
    wr     = POS - keep;
    slot_d = 8'h00;
    if (POS < keep)
      slot_d = buf_q[src];
    else if (wr < added)
      slot_d = in_arr[wr[CW-1:0]];
  end
endmodule

module stream_fragmenter #(
  parameter int DATA_BYTES = 8,
  localparam int CW = $clog2(DATA_BYTES),
  localparam int AW = CW + 1,
  localparam int OW = $clog2(2*DATA_BYTES+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [CW-1:0]           in_cnt,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CW-1:0]           req_cnt,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [CW-1:0]           out_cnt,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [2*DATA_BYTES-1:0][7:0] buf_q, buf_d;
  logic [DATA_BYTES-1:0][7:0]   in_arr, out_arr;

  logic [OW-1:0] occ, occ_d, keep, added;
  logic [AW-1:0] req_bytes, in_bytes, take, taken;
  logic          last_held, last_d, in_ready_d;
  logic          in_xfer, out_xfer, avail;

  assign in_arr    = in_data;
  assign req_bytes = {1'b0, req_cnt} + AW'(1);
  assign in_bytes  = {1'b0, in_cnt} + AW'(1);

  // ---------------- output side (pure function of state + request) -------
  // A full-size beat needs req_bytes held; a packet tail may go out short.
  assign avail     = (occ >= OW'(req_bytes)) || (last_held && (occ != '0));
  assign out_valid = req_valid && avail;
  assign take      = (OW'(req_bytes) < occ) ? req_bytes : occ[AW-1:0];

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_out
    assign out_arr[i] = (out_valid && (AW'(i) < take)) ? buf_q[i] : 8'h00;
  end

  assign out_data  = out_arr;
  assign out_cnt   = out_valid ? CW'(take - AW'(1)) : '0;
  assign out_last  = out_valid && last_held && (OW'(take) == occ);
  assign req_ready = out_valid && out_ready;

  // ---------------- per-edge bookkeeping ----------------------------------
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = req_ready;
  assign taken    = out_xfer ? take : '0;
  assign added    = in_xfer ? OW'(in_bytes) : '0;
  assign keep     = occ - OW'(taken);
  assign occ_d    = keep + added;

  // Set wins over clear; in_ready keeps the two from meeting in practice.
  always_comb begin
    last_d = last_held;
    if (out_xfer && out_last) last_d = 1'b0;
    if (in_xfer && in_last)   last_d = 1'b1;
  end

  // Only accept when a whole beat is guaranteed to fit next cycle, which
  // bounds occupancy at 2*DATA_BYTES without looking at in_valid.
  assign in_ready_d = !last_d && (occ_d <= OW'(DATA_BYTES));

  for (genvar s = 0; s < 2*DATA_BYTES; s++) begin : g_slot
    stream_fragmenter_slot #(
      .DATA_BYTES (DATA_BYTES),
      .IDX        (s)
    ) u_slot (
      .buf_q  (buf_q),
      .in_arr (in_arr),
      .taken  (taken),
      .keep   (keep),
      .added  (added),
      .slot_d (buf_d[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      occ       <= '0;
      last_held <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      occ       <= occ_d;
      last_held <= last_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_stream_fragmenter.sv
module tb_stream_fragmenter;
  localparam int DB = 8;
  localparam int CW = $clog2(DB);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [8*DB-1:0] in_data = '0;
  logic [CW-1:0] in_cnt = '0;
  logic          in_last = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] req_cnt = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [8*DB-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_last, out_valid;
  logic          out_ready = 1'b1;

  stream_fragmenter #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .req_cnt(req_cnt), .req_valid(req_valid), .req_ready(req_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit aborted = 0;

  typedef struct { logic [63:0] data; logic [CW-1:0] cnt; logic last; } beat_t;
  beat_t blog[$];
  int    consumed = 0;

  // reference model: held bytes as a plain queue plus end-of-packet flag
  byte unsigned mq[$];
  bit  mlast = 0, exp_in_ready = 0;
  bit  m_in_xfer = 0, m_out_xfer = 0, m_out_last = 0;
  int  m_take = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    aborted = 1;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic [63:0] d,
                          input int c, input bit l);
    if (idx >= blog.size()) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] missing beat log_size=%0d", nm, idx, blog.size());
    end else begin
      chk({nm, "_data"}, blog[idx].data, d);
      chk({nm, "_cnt"},  64'(blog[idx].cnt), 64'(c));
      chk({nm, "_last"}, 64'(blog[idx].last), 64'(l));
    end
  endtask

  // compare process: outputs are settled mid-cycle; inputs change at posedge+1
  always begin
    @(negedge clk);
    if (!rst_n) begin
      m_in_xfer  = 0;
      m_out_xfer = 0;
      chk("rst_in_ready",  64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_out_data",  out_data, 64'(0));
      chk("rst_out_cnt",   64'(out_cnt), 64'(0));
      chk("rst_out_last",  64'(out_last), 64'(0));
    end else begin
      int n, rb, tk;
      logic [63:0] ed;
      bit ev, el;
      n  = mq.size();
      rb = int'(req_cnt) + 1;
      ev = req_valid && ((n >= rb) || (mlast && n > 0));
      tk = (rb < n) ? rb : n;
      el = mlast && (tk == n);
      ed = '0;
      for (int i = 0; i < tk; i++) ed[8*i +: 8] = mq[i];
      chk("in_ready",  64'(in_ready), 64'(exp_in_ready));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("req_ready", 64'(req_ready), 64'(ev && out_ready));
      if (ev) begin
        chk("out_data", out_data, ed);
        chk("out_cnt",  64'(out_cnt), 64'(tk - 1));
        chk("out_last", 64'(out_last), 64'(el));
      end
      m_in_xfer  = in_valid && exp_in_ready;
      m_out_xfer = ev && out_ready;
      m_take     = tk;
      m_out_last = el;
      if (out_valid && out_ready) begin
        blog.push_back('{out_data, out_cnt, out_last});
        consumed += int'(out_cnt) + 1;
      end
    end
  end

  // model update at the clock edge (and immediately on reset assertion)
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mlast        = 0;
      exp_in_ready = 0;
    end else begin
      if (m_in_xfer && in_last) begin
        checks++;
        if (m_out_xfer && m_out_last) begin
          failures++;
          $display("FAIL last_set_clear_same_edge t=%0t", $time);
        end
      end
      if (m_out_xfer) begin
        repeat (m_take) void'(mq.pop_front());
        if (m_out_last) mlast = 0;
      end
      if (m_in_xfer) begin
        for (int i = 0; i <= int'(in_cnt); i++) mq.push_back(in_data[8*i +: 8]);
        if (in_last) mlast = 1;
      end
      exp_in_ready = !mlast && (mq.size() <= DB);
      m_in_xfer  = 0;
      m_out_xfer = 0;
    end
  end

  task automatic push_beat(input logic [63:0] d, input int cnt, input bit last);
    bit ok = 0;
    in_data = d; in_cnt = CW'(cnt); in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) timeout("push_beat");
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_cnt = '0; in_last = 1'b0;
  endtask

  task automatic request(input int cnt);
    bit ok = 0;
    req_cnt = CW'(cnt); req_valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = req_ready;
    end
    if (!ok) timeout("request");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, total, start;
    bit done;
    int plen[12];
    logic [63:0] es[6];
    int ec[6];

    // ---- reset ----
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready",  64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;

    // ---- even split ----
    base = blog.size();
    fork
      push_beat(64'h0807060504030201, 7, 1);
      repeat (4) request(1);
    join
    es[0] = 64'h0201; es[1] = 64'h0403; es[2] = 64'h0605; es[3] = 64'h0807;
    for (int k = 0; k < 4; k++) chk_beat("even", base + k, es[k], 1, k == 3);
    @(negedge clk);
    chk("even_in_ready_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // ---- spanning beats ----
    base = blog.size();
    fork
      begin
        push_beat(64'h0807060504030201, 7, 0);
        push_beat(64'h100F0E0D0C0B0A09, 7, 1);
      end
      repeat (6) request(2);
    join
    es[0] = 64'h030201; es[1] = 64'h060504; es[2] = 64'h090807;
    es[3] = 64'h0C0B0A; es[4] = 64'h0F0E0D; es[5] = 64'h10;
    ec[0] = 2; ec[1] = 2; ec[2] = 2; ec[3] = 2; ec[4] = 2; ec[5] = 0;
    for (int k = 0; k < 6; k++) chk_beat("span", base + k, es[k], ec[k], k == 5);

    // ---- short final beat ----
    base = blog.size();
    fork
      push_beat(64'hFFFF_FFFF_FFCC_BBAA, 2, 1);
      request(7);
    join
    chk_beat("short", base, 64'h0000000000CCBBAA, 2, 1);

    // ---- backpressure ----
    out_ready = 1'b0;
    push_beat(64'h2827262524232221, 7, 1);
    req_cnt = 3; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid",     64'(out_valid), 64'(1));
      chk("bp_data",      out_data, 64'h24232221);
      chk("bp_cnt",       64'(out_cnt), 64'(3));
      chk("bp_last",      64'(out_last), 64'(0));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    base = blog.size();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("bp_one_beat", 64'(blog.size() - base), 64'(1));
    chk_beat("bp_beat", base, 64'h24232221, 3, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = blog.size();
    request(3);
    chk_beat("bp_tail", base, 64'h28272625, 3, 1);

    // ---- mid-packet reset ----
    base = blog.size();
    fork
      push_beat(64'h0807060504030201, 7, 1);
      request(4);
    join
    chk_beat("mid_first", base, 64'h0504030201, 4, 0);
    out_ready = 1'b0; req_cnt = 2; req_valid = 1'b1;
    @(negedge clk);
    chk("mid_pre_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_post_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    base = blog.size();
    fork
      push_beat(64'h1817161514131211, 7, 1);
      request(7);
    join
    chk_beat("mid_next", base, 64'h1817161514131211, 7, 1);

    // ---- randomized traffic ----
    total = 0;
    for (int p = 0; p < 12; p++) begin
      plen[p] = $urandom_range(1, 40);
      total += plen[p];
    end
    start = consumed;
    done  = 0;
    fork
      begin
        int rem, nb;
        logic [63:0] d;
        for (int p = 0; p < 12 && !aborted; p++) begin
          rem = plen[p];
          while (rem > 0 && !aborted) begin
            nb = (rem > DB) ? DB : rem;
            d  = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push_beat(d, nb - 1, rem == nb);
            rem -= nb;
          end
        end
      end
      begin
        while ((consumed - start) < total && !aborted) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          request($urandom_range(0, DB - 1));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    chk("rand_bytes_total", 64'(consumed - start), 64'(total));

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
